// File: rtl/csr_exec.sv
// csr_exec: runs one Zicsr read-modify-write against the CSR file's
// enable/busy port and returns the old value (or an illegal flag).
module csr_exec #(
  parameter int CSR_DATA_WIDTH = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] req_rs1_i,
  input  logic [4:0]                req_rs1_idx_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [CSR_DATA_WIDTH-1:0] rsp_data_o,
  output logic                      rsp_illegal_o,
  output logic                      csr_en_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_data_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_data_i,
  input  logic                      csr_busy_i,
  input  logic                      csr_exists_i,
  input  logic                      csr_ro_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RESP
  } state_t;

  state_t r_state, w_next;

  logic [2:0]                r_funct3;
  logic [CSR_ADDR_WIDTH-1:0] r_addr;
  logic [CSR_DATA_WIDTH-1:0] r_rs1;
  logic [4:0]                r_rs1_idx;
  logic [CSR_DATA_WIDTH-1:0] r_old;
  logic                      r_illegal;
  logic                      r_seen_busy;
  logic [CSR_DATA_WIDTH-1:0] r_wdata;

  logic                      w_accept;
  logic                      w_f3_bad;
  logic [CSR_DATA_WIDTH-1:0] w_src;
  logic [CSR_DATA_WIDTH-1:0] w_new;
  logic                      w_wr_intent;
  logic                      w_illegal;
  logic                      w_wait_done;

  assign w_accept    = req_valid_i && (r_state == S_IDLE);
  assign w_f3_bad    = (req_funct3_i[1:0] == 2'b00);
  assign w_src       = r_funct3[2] ? {{(CSR_DATA_WIDTH-5){1'b0}}, r_rs1_idx} : r_rs1;
  // set/clear forms with a zero rs1 field are pure reads
  assign w_wr_intent = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
  assign w_illegal   = !csr_exists_i ||
                       (w_wr_intent && (csr_ro_i ||
                        (r_addr[CSR_ADDR_WIDTH-1 -: 2] == 2'b11)));
  // a wait completes only after busy has been seen high and then drops
  assign w_wait_done = r_seen_busy && !csr_busy_i;

  // new CSR value from the read data, valid in the RD_WAIT sample cycle
  always_comb begin
    w_new = w_src;
    case (r_funct3[1:0])
      2'b10:   w_new = csr_data_i | w_src;
      2'b11:   w_new = csr_data_i & ~w_src;
      default: w_new = w_src;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state decode and state-derived outputs
  always_comb begin
    w_next        = r_state;
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    csr_en_o      = 1'b0;
    csr_we_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_next = w_f3_bad ? S_RESP : S_RD_REQ;
      end
      S_RD_REQ: begin
        csr_en_o = 1'b1;
        w_next   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_wait_done) w_next = (!w_illegal && w_wr_intent) ? S_WR_REQ : S_RESP;
      end
      S_WR_REQ: begin
        csr_en_o = 1'b1;
        csr_we_o = 1'b1;
        w_next   = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (w_wait_done) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, read sample, write data and busy tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_funct3    <= '0;
      r_addr      <= '0;
      r_rs1       <= '0;
      r_rs1_idx   <= '0;
      r_old       <= '0;
      r_illegal   <= 1'b0;
      r_seen_busy <= 1'b0;
      r_wdata     <= '0;
    end else begin
      if (w_accept) begin
        r_funct3  <= req_funct3_i;
        r_addr    <= req_addr_i;
        r_rs1     <= req_rs1_i;
        r_rs1_idx <= req_rs1_idx_i;
        r_old     <= '0;
        r_illegal <= w_f3_bad;
      end
      if (r_state == S_RD_WAIT && w_wait_done) begin
        r_old     <= w_illegal ? '0 : csr_data_i;
        r_illegal <= w_illegal;
        if (!w_illegal && w_wr_intent) r_wdata <= w_new;
      end
      if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) begin
        if (w_wait_done)     r_seen_busy <= 1'b0;
        else if (csr_busy_i) r_seen_busy <= 1'b1;
      end else begin
        r_seen_busy <= 1'b0;
      end
    end
  end

  assign rsp_data_o    = r_old;
  assign rsp_illegal_o = r_illegal;
  assign csr_addr_o    = r_addr;
  assign csr_data_o    = r_wdata;

endmodule
